dmem_sized_hs: RTL
==================

Name: dmem_sized_hs

Overview:
- Parametrised single-port data memory for the RV64 sequential/pipelined core.
- Serves byte, half, word and double loads/stores (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) through byte-lane merging on a 64-bit word array.
- Uses a valid/ready request channel and a registered, back-pressurable response channel.
- Sits between the core's MEM stage (or a future cache) and the word array; flags misaligned and out-of-range accesses instead of silently aliasing.

Parameters:
- DEPTH, 256: number of 64-bit words; power of two, 2..65536.
- ADDR_W, 64: byte-address width; must be >= log2(DEPTH)+3.
- INIT_WORDS, 9: words preloaded at time 0 with memory[i] = i for i < INIT_WORDS; 0 disables preload.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  zero-extend load result (LBU/LHU/LWU); ignored for stores and doubles.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data; uses the low 8/16/32/64 bits per req_size.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  64  load result, extended to 64 bits; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset (async assert, sync-style deassert on next posedge):
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Memory array is not cleared; contents survive reset.
- req_ready = !rsp_valid || rsp_ready (one-entry response register). It is combinational from rsp_valid and rsp_ready only, never from req_valid.
- Accept = req_valid && req_ready, sampled on posedge. No other input is sampled.
- Latency:
  - Response appears exactly 1 cycle after accept (rsp_valid = 1 from the next posedge).
  - Back-to-back accepts are allowed every cycle while rsp_ready = 1.
- Hold rule: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err hold stable and no new request is accepted.
- Response retirement: when rsp_valid && rsp_ready and there is no accept in the same cycle, rsp_valid drops to 0 on the next posedge.
- Decode:
  - idx = req_addr[log2(DEPTH)+2:3]; lane = req_addr[2:0].
  - Misaligned when lane is not a multiple of the size (half: lane[0] != 0; word: lane[1:0] != 0; double: lane != 0).
  - Out of range when any req_addr bit above log2(DEPTH)+2 is non-zero.
- Error access: no memory write, rsp_err = 1, rsp_rdata = 0. A response is still produced with the normal latency.
- Store:
  - Byte-enable mask from size and lane.
  - memory[idx] bytes under the mask are replaced by the low req_wdata bytes, shifted to the lane. Other bytes are unchanged.
  - Write occurs on the accept posedge.
  - Response: rsp_rdata = 0, rsp_err = 0.
- Load:
  - Read memory[idx] and shift right by lane*8.
  - Truncate to the access size; sign-extend from the top bit unless req_unsigned (doubles are never extended).
- Simultaneous events:
  - A load accepted in the cycle after a store to the same word returns the updated data.
  - A single port means no same-cycle read/write conflict exists.
- Reset mid-operation: a pending response is discarded and a write is never partially applied. The store either committed on an earlier posedge or not at all.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds outputs load_cnt [31:0], store_cnt [31:0] and err_cnt [31:0].
  - Each increments by 1 on every accepted load, accepted non-error store, and accepted error access respectively.
  - All cleared by rst_n; wrap modulo 2^32.
  - An error access increments only err_cnt.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Preload check: after reset, LD at addr 0x18 -> rsp one cycle later, rsp_rdata = 0x3, rsp_err = 0. LD at addr 0x40 -> 0x8.
- Byte merge: SD 0x1122334455667788 @0x20, then SB 0xAB @0x23, then LD @0x20 -> 0x11223344AB667788.
- Sign extension: SW 0x80000001 @0x30. LW @0x30 -> 0xFFFFFFFF80000001. LWU @0x30 -> 0x0000000080000001. LB @0x33 -> 0xFFFFFFFFFFFFFF80. LHU @0x32 -> 0x8000.
- Errors: LH @0x21 -> rsp_err = 1, rsp_rdata = 0. SD @0x804 (DEPTH 256) -> rsp_err = 1, word 0 unchanged. With DMEM_PERF_CNT_EN defined, err_cnt = 2.
- Back-pressure: hold rsp_ready = 0 for 3 cycles after an accepted LD @0x08 -> req_ready = 0, rsp_rdata = 0x1 stable. Raise rsp_ready -> req_ready = 1 the same cycle and the next request is accepted.
- Async reset: pulse rst_n low between cycles with a response pending -> rsp_valid = 0 immediately. Memory contents written before reset read back unchanged.

Source files
------------

// File: rtl/dmem_sized_hs.sv
// dmem_sized_hs: single-port 64-bit data memory for the RV64 core.
// It serves byte, half, word and double loads and stores by merging byte
// lanes into one 64-bit word of the array.
//
// Handshake contract, identical on both channels:
//   - A transfer happens on a posedge where valid && ready.
//   - The producer holds valid and its payload stable until that transfer.
//   - req_ready depends only on the response register and rsp_ready. It
//     never depends on req_valid, so the request channel has no
//     combinational loop.
//   - The response comes one cycle after accept. It holds while
//     rsp_valid && !rsp_ready.
//
// Misaligned and out-of-range accesses do not write memory. They return
// rsp_err = 1 with rsp_rdata = 0.
//
// Optional build macro DMEM_PERF_CNT_EN adds load, store and error counters.
module dmem_sized_hs #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 64,
    parameter int INIT_WORDS = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
`ifdef DMEM_PERF_CNT_EN
    output logic [31:0]       load_cnt,
    output logic [31:0]       store_cnt,
    output logic [31:0]       err_cnt,
`endif
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [DEPTH-1:0][63:0] mem_t;

    // Power-on image: word i holds the value i for the first INIT_WORDS words.
    function automatic mem_t preload_image();
        mem_t m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < INIT_WORDS) m[i] = 64'(i);
        end
        return m;
    endfunction

    // The array has no reset, so its contents survive rst_n.
    mem_t mem_q = preload_image();

    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [2:0]       lane;
    logic [5:0]       lane_sh;
    logic             misaligned;
    logic             out_of_range;
    logic             acc_err;
    logic [7:0]       byte_en;
    logic [63:0]      bit_en;
    logic [63:0]      rd_word;
    logic [63:0]      rd_shift;
    logic [63:0]      load_data;
    logic [63:0]      store_word;
    logic             mem_we;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    assign idx     = req_addr[IDX_W+2:3];
    assign lane    = req_addr[2:0];
    assign lane_sh = {lane, 3'b000};
    assign rd_word = mem_q[idx];

    // Decode the access: alignment, range, lane masks, merged store word and extended load value.
    always_comb begin
        misaligned   = 1'b0;
        byte_en      = 8'h00;
        load_data    = 64'd0;
        bit_en       = 64'd0;
        out_of_range = (req_addr >> (IDX_W + 3)) != '0;
        rd_shift     = rd_word >> lane_sh;
        case (req_size)
            2'b00: begin
                byte_en   = 8'h01 << lane;
                load_data = req_unsigned ? {56'd0, rd_shift[7:0]}
                                         : {{56{rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b01: begin
                misaligned = lane[0];
                byte_en    = 8'h03 << lane;
                load_data  = req_unsigned ? {48'd0, rd_shift[15:0]}
                                          : {{48{rd_shift[15]}}, rd_shift[15:0]};
            end
            2'b10: begin
                misaligned = lane[1:0] != 2'b00;
                byte_en    = 8'h0F << lane;
                load_data  = req_unsigned ? {32'd0, rd_shift[31:0]}
                                          : {{32{rd_shift[31]}}, rd_shift[31:0]};
            end
            default: begin
                misaligned = lane != 3'b000;
                byte_en    = 8'hFF;
                load_data  = rd_shift;
            end
        endcase
        for (int b = 0; b < 8; b++) begin
            bit_en[8*b +: 8] = {8{byte_en[b]}};
        end
        acc_err    = misaligned || out_of_range;
        store_word = (rd_word & ~bit_en) | ((req_wdata << lane_sh) & bit_en);
        mem_we     = accept && req_we && !acc_err;
    end

    // Next response: load a new result on accept, hold while stalled, retire when consumed.
    always_comb begin
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (req_we || acc_err) ? 64'd0 : load_data;
        end
    end

    // Response register; reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Store commit: the whole merged word is written on the accept edge.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= store_word;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] load_cnt_q,  load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] err_cnt_q,   err_cnt_d;

    // Count each accepted access into exactly one bucket; errors go only to err_cnt.
    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            if (acc_err)     err_cnt_d   = err_cnt_q + 32'd1;
            else if (req_we) store_cnt_d = store_cnt_q + 32'd1;
            else             load_cnt_d  = load_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset and wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
            err_cnt_q   <= 32'd0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
